word_bank: RTL and testbench

- Parametrised successor to the single 8-bit word: a clocked bank of DEPTH words, each WIDTH bits, with byte-granular writes and registered reads.
- Uses a req/ready request handshake and a one-cycle rvalid read response.
- Clears its contents by a post-reset sweep.
- Sits between the address decoder and the data path of the memory project; replaces flat arrays of word instances.

---
 rtl/word_bank_pkg.sv | 7 +
 rtl/word_reg.sv | 32 +++
 rtl/word_bank.sv | 93 +++++++++
 tb/tb_word_bank.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/word_bank_pkg.sv
// word_bank_pkg: shared FSM states, request encodings and byte width for word_bank.
package word_bank_pkg;
  typedef enum logic {CLEAR, IDLE} state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/word_reg.sv
// word_reg: one WIDTH-bit storage word with byte-enabled write and combinational read.
// With WORD_BANK_PARITY_EN an even-parity bit over the merged word is stored alongside.
module word_reg
  import word_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WIDTH/BYTE_W-1:0]  be,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         q
`ifdef WORD_BANK_PARITY_EN
  ,
  output logic                     par
`endif
);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  for (genvar k = 0; k < WIDTH / BYTE_W; k++) begin : g_b
    assign w_next[k*BYTE_W +: BYTE_W] = be[k] ? wdata[k*BYTE_W +: BYTE_W] : r_q[k*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk)
    if (we) r_q <= w_next;
  assign q = r_q;
`ifdef WORD_BANK_PARITY_EN
  logic r_par;
  always_ff @(posedge clk)
    if (we) r_par <= ^w_next;
  assign par = r_par;
`endif
endmodule

// File: rtl/word_bank.sv
// word_bank: DEPTH x WIDTH word bank, byte-enabled writes, registered reads, post-reset clear sweep.
// Optional WORD_BANK_PARITY_EN adds per-word even parity and a par_err read flag.
module word_bank
  import word_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    rw,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [WIDTH/BYTE_W-1:0] be,
  output logic                    ready,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rvalid,
  output logic                    addr_err
`ifdef WORD_BANK_PARITY_EN
  ,
  output logic                    par_err
`endif
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_rvalid, r_addr_err;
  logic              w_clr, w_acc, w_rd, w_in, w_last;
  logic [WIDTH-1:0]  w_q [DEPTH];
  assign ready  = r_state == IDLE;
  assign w_clr  = r_state == CLEAR && !rst;
  assign w_acc  = req && ready && !rst;
  assign w_rd   = w_acc && rw == RW_READ;
  assign w_in   = {1'b0, addr} < DEPTH_L;
  assign w_last = r_cnt == ADDR_W'(DEPTH - 1);
`ifdef WORD_BANK_PARITY_EN
  logic [DEPTH-1:0] w_p;
  logic             r_par_err;
  assign par_err = r_par_err;
`endif
  // Out-of-range writes never match any word index, so they are dropped here.
  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    word_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .we    (w_clr ? r_cnt == ADDR_W'(i) : w_acc && rw == RW_WRITE && addr == ADDR_W'(i)),
      .be    (w_clr ? '1 : be),
      .wdata (w_clr ? '0 : wdata),
      .q     (w_q[i])
`ifdef WORD_BANK_PARITY_EN
      ,
      .par   (w_p[i])
`endif
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == CLEAR) begin
      w_state_nxt = w_last ? IDLE : CLEAR;
      w_cnt_nxt   = w_last ? '0 : r_cnt + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_addr_err <= 1'b0;
`ifdef WORD_BANK_PARITY_EN
      r_par_err  <= 1'b0;
`endif
    end else begin
      r_rvalid   <= w_rd;
      r_addr_err <= w_acc && !w_in;
      if (w_rd) r_rdata <= w_in ? w_q[addr] : '0;
`ifdef WORD_BANK_PARITY_EN
      r_par_err  <= w_rd && w_in && ((^w_q[addr]) != w_p[addr]);
`endif
    end
  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign addr_err = r_addr_err;
endmodule

// File: tb/tb_word_bank.sv
// tb_word_bank: directed self-checking bench for word_bank (WIDTH=16, DEPTH=12).
module tb_word_bank;
  localparam int W = 16;
  localparam int D = 12;
  localparam int AW = $clog2(D);
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          rw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W/8-1:0] be = '0;
  logic          ready, rvalid, addr_err;
  logic [W-1:0]  rdata;
  int            n_chk = 0;
  int            n_bad = 0;
  logic [W-1:0]  exp_m [D];
`ifdef WORD_BANK_PARITY_EN
  logic          par_err;
`endif
  word_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .be       (be),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .addr_err (addr_err)
`ifdef WORD_BANK_PARITY_EN
    ,
    .par_err  (par_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic r, input int a, input logic [W-1:0] d, input logic [W/8-1:0] b);
    req = 1'b1; rw = r; addr = AW'(a); wdata = d; be = b;
    cyc;
    req = 1'b0;
  endtask
  initial begin
    int first;
    cyc; cyc;
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr_err", addr_err, 0);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= D + 2; i++) begin
      cyc;
      if (ready && first == 0) first = i;
    end
    chk("sweep_len", first, D);
    for (int a = 0; a < D; a++) begin
      exp_m[a] = '0;
      op(1'b1, a, '0, '0);
      chk("clr_rvalid", rvalid, 1);
      chk("clr_rdata", rdata, 0);
    end
    op(1'b0, 5, 16'h00A5, 2'b01);
    chk("wr_no_rvalid", rvalid, 0);
    op(1'b1, 5, '0, '0);
    chk("rb_rvalid", rvalid, 1);
    chk("rb_rdata", rdata, 16'h00A5);
    cyc; cyc;
    chk("hold_rvalid", rvalid, 0);
    chk("hold_rdata", rdata, 16'h00A5);
    exp_m[5] = 16'h00A5;
    op(1'b0, 3, 16'hBEEF, 2'b11);
    op(1'b0, 3, 16'h1234, 2'b01);
    op(1'b1, 3, '0, '0);
    chk("be_lo", rdata, 16'hBE34);
    op(1'b0, 3, 16'hFFFF, 2'b00);
    op(1'b1, 3, '0, '0);
    chk("be_none", rdata, 16'hBE34);
    op(1'b0, 3, 16'h7799, 2'b10);
    op(1'b1, 3, '0, '0);
    chk("be_hi", rdata, 16'h7734);
    exp_m[3] = 16'h7734;
    op(1'b0, 13, 16'hFFFF, 2'b11);
    chk("oor_wr_err", addr_err, 1);
    chk("oor_wr_rvalid", rvalid, 0);
    op(1'b1, 13, '0, '0);
    chk("oor_rd_err", addr_err, 1);
    chk("oor_rd_rvalid", rvalid, 1);
    chk("oor_rd_rdata", rdata, 0);
    op(1'b1, D, '0, '0);
    chk("oor_edge_err", addr_err, 1);
    op(1'b1, D - 1, '0, '0);
    chk("last_err", addr_err, 0);
    chk("last_rvalid", rvalid, 1);
    cyc;
    chk("err_pulse", addr_err, 0);
    for (int a = 0; a < D; a++) begin
      op(1'b1, a, '0, '0);
      chk("bank_rdata", rdata, exp_m[a]);
    end
    op(1'b1, 5, '0, '0);
    req = 1'b1; rw = 1'b1; addr = AW'(5); rst = 1'b1;
    cyc;
    req = 1'b0;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_ready", ready, 0);
    cyc;
    chk("held_rst_ready", ready, 0);
    rst = 1'b0;
    repeat (D - 1) cyc;
    chk("resweep_busy", ready, 0);
    cyc;
    chk("resweep_done", ready, 1);
    op(1'b1, 5, '0, '0);
    chk("resweep_rvalid", rvalid, 1);
    chk("resweep_rdata", rdata, 0);
`ifdef WORD_BANK_PARITY_EN
    op(1'b0, 2, 16'h0007, 2'b11);
    force dut.g_w[2].u_reg.r_q = 16'h0006;
    op(1'b1, 2, '0, '0);
    chk("par_bad_rvalid", rvalid, 1);
    chk("par_bad", par_err, 1);
    release dut.g_w[2].u_reg.r_q;
    op(1'b0, 2, 16'h0007, 2'b11);
    op(1'b1, 2, '0, '0);
    chk("par_clean", par_err, 0);
    chk("par_clean_rdata", rdata, 16'h0007);
    op(1'b1, 13, '0, '0);
    chk("par_oor", par_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
